// File: rtl/set_pkg.sv
// Shared definitions for the set-engine host.
//   - job field widths and the packed job record stored in the job FIFO
//   - host FSM state encoding
//   - set-operation mode codes understood by the engine
//   - timer_width(): bits needed to count up to a given cycle limit
package set_pkg;

  localparam int unsigned CoordW   = 4;
  localparam int unsigned CentralW = 6 * CoordW;  // {ax,ay,bx,by,cx,cy}
  localparam int unsigned RadiusW  = 3 * CoordW;  // {ra,rb,rc}
  localparam int unsigned ModeW    = 2;
  localparam int unsigned TagW     = 4;
  localparam int unsigned JobW     = CentralW + RadiusW + ModeW + TagW;

  // Set-operation codes forwarded untouched to the engine.
  localparam logic [ModeW-1:0] ModeSingle = 2'd0;
  localparam logic [ModeW-1:0] ModeAnd    = 2'd1;
  localparam logic [ModeW-1:0] ModeOr     = 2'd2;
  localparam logic [ModeW-1:0] ModeDiff   = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StHold
  } state_e;

  typedef struct packed {
    logic [CentralW-1:0] central;
    logic [RadiusW-1:0]  radius;
    logic [ModeW-1:0]    mode;
    logic [TagW-1:0]     tag;
  } job_t;

  function automatic int unsigned timer_width(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/set_job_fifo.sv
// Job FIFO for the set-engine host.
//   clk, rst     : clock, asynchronous active-low reset (drops all entries)
//   push_i       : write request, ignored while full
//   push_data_i  : job record to store
//   full_o       : no free entry
//   pop_i        : drop the head entry, ignored while empty
//   head_o       : oldest entry (meaningless while empty)
//   empty_o      : no stored entry (registered, so a push is never bypassed to the head)
module set_job_fifo
  import set_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  job_t push_data_i,
  output logic full_o,
  input  logic pop_i,
  output job_t head_o,
  output logic empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW:0] FullCount = (PtrW + 1)'(Depth);

  job_t            mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic            do_push, do_pop;

  assign full_o  = (count_q == FullCount);
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Depth is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/set_host.sv
// Host for the set-counting engine: queues jobs, issues them one at a time, waits for the
// engine result (or a timeout) and holds it until the consumer takes it.
//   clk, rst                     : clock, asynchronous active-low reset
//   job_valid/job_ready          : job handshake into the FIFO
//   job_central/radius/mode/tag  : job fields
//   en                           : engine load strobe (combinational on busy)
//   central/radius/mode          : job fields to the engine
//   busy, valid, candidate       : engine status, result strobe, result count
//   res_valid/res_ready          : result handshake
//   res_tag/res_count/res_err    : result tag, count (8'hFF on timeout), timeout flag
//   done_cnt                     : number of results taken by the consumer (wraps)
module set_host
  import set_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 127
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                job_valid,
  output logic                job_ready,
  input  logic [CentralW-1:0] job_central,
  input  logic [RadiusW-1:0]  job_radius,
  input  logic [ModeW-1:0]    job_mode,
  input  logic [TagW-1:0]     job_tag,
  output logic                en,
  output logic [CentralW-1:0] central,
  output logic [RadiusW-1:0]  radius,
  output logic [ModeW-1:0]    mode,
  input  logic                busy,
  input  logic                valid,
  input  logic [7:0]          candidate,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [TagW-1:0]     res_tag,
  output logic [7:0]          res_count,
  output logic                res_err,
  output logic [15:0]         done_cnt
);

  localparam int unsigned TimerW = timer_width(TIMEOUT);
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT);

  state_e state_q, state_d;

  job_t job_in, fifo_head;
  logic fifo_full, fifo_empty;

  logic [CentralW-1:0] central_q;
  logic [RadiusW-1:0]  radius_q;
  logic [ModeW-1:0]    mode_q;
  logic [TagW-1:0]     res_tag_q;
  logic [7:0]          res_count_q, res_count_d;
  logic                res_err_q, res_err_d;
  logic [TimerW-1:0]   timer_q, timer_d, timer_inc;
  logic                timer_expire;
  logic [15:0]         done_cnt_q;
  logic                res_load, res_done;

  assign job_in.central = job_central;
  assign job_in.radius  = job_radius;
  assign job_in.mode    = job_mode;
  assign job_in.tag     = job_tag;

  set_job_fifo #(
    .Depth(FIFO_DEPTH)
  ) u_job_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (job_valid),
    .push_data_i(job_in),
    .full_o     (fifo_full),
    .pop_i      (en),
    .head_o     (fifo_head),
    .empty_o    (fifo_empty)
  );

  // Saturating increment; expiry is flagged in the cycle the timer would reach the limit.
  assign timer_inc    = (timer_q == TimerMax) ? timer_q : timer_q + 1'b1;
  assign timer_expire = (timer_inc == TimerMax);

  always_comb begin
    state_d     = state_q;
    en          = 1'b0;
    timer_d     = timer_q;
    res_load    = 1'b0;
    res_count_d = res_count_q;
    res_err_d   = res_err_q;
    res_done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty && !res_valid) state_d = StIssue;
      end
      StIssue: begin
        if (!busy) begin
          en      = 1'b1;
          timer_d = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        timer_d = timer_inc;
        // A result arriving in the expiry cycle still counts as a result.
        if (valid) begin
          res_load    = 1'b1;
          res_count_d = candidate;
          res_err_d   = 1'b0;
          state_d     = StHold;
        end else if (timer_expire) begin
          res_load    = 1'b1;
          res_count_d = 8'hFF;
          res_err_d   = 1'b1;
          state_d     = StHold;
        end
      end
      StHold: begin
        if (res_ready) begin
          res_done = 1'b1;
          state_d  = fifo_empty ? StIdle : StIssue;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      central_q   <= '0;
      radius_q    <= '0;
      mode_q      <= '0;
      res_tag_q   <= '0;
      res_count_q <= '0;
      res_err_q   <= 1'b0;
      timer_q     <= '0;
      done_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      if (en) begin
        central_q <= fifo_head.central;
        radius_q  <= fifo_head.radius;
        mode_q    <= fifo_head.mode;
        res_tag_q <= fifo_head.tag;
      end
      if (res_load) begin
        res_count_q <= res_count_d;
        res_err_q   <= res_err_d;
      end
      if (res_done) done_cnt_q <= done_cnt_q + 16'd1;
    end
  end

  // The head is presented while issuing; otherwise the last issued job stays on the bus.
  assign central   = (state_q == StIssue) ? fifo_head.central : central_q;
  assign radius    = (state_q == StIssue) ? fifo_head.radius  : radius_q;
  assign mode      = (state_q == StIssue) ? fifo_head.mode    : mode_q;
  assign job_ready = ~fifo_full;
  assign res_valid = (state_q == StHold);
  assign res_tag   = res_tag_q;
  assign res_count = res_count_q;
  assign res_err   = res_err_q;
  assign done_cnt  = done_cnt_q;

endmodule
